// File: rtl/interrupt_sequencer_if.sv
// CPU memory bus shared by the interrupt sequencer and memory.
// The sequencer is the master whenever busy is high.
interface interrupt_sequencer_if;
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        read_write;
    logic [7:0]  data_in;

    modport master (
        output busy,
        output addr,
        output data_out,
        output read_write,
        input  data_in
    );

    modport slave (
        input  busy,
        input  addr,
        input  data_out,
        input  read_write,
        output data_in
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502 reset/IRQ/NMI entry sequencer: pushes PC and P, then loads PC from a vector.
// Define INTSEQ_NMI_EN to include the NMI edge detector and NMI vector selection.
module interrupt_sequencer (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          nmi_n,
    input  logic                          irq_n,
    input  logic                          i_flag,
    input  logic                          instr_boundary,
    input  logic [15:0]                   pc,
    input  logic [7:0]                    status,
    input  logic [7:0]                    sp,
    interrupt_sequencer_if.master         bus,
    output logic                          sp_decrement,
    output logic                          pcl_load,
    output logic                          pch_load,
    output logic                          set_i
);
    localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;
    localparam logic [7:0]  STACK_PAGE   = 8'h01;

    typedef enum logic [3:0] {
        RESET, RST_L, RST_H, IDLE,
        PUSH_PCH, PUSH_PCL, PUSH_P, VEC_L, VEC_H
    } state_t;

    typedef enum logic {KIND_IRQ = 1'b0, KIND_NMI = 1'b1} kind_t;

    state_t      state_reg, state_next;
    kind_t       kind_reg;
    logic [15:0] pc_hold_reg;
    logic        nmi_pending;
    logic        take;
    logic [15:0] vec_base;

    // The external PC register consumes data_in directly; B and the unused bit
    // are forced in the pushed P, so status[5:4] never reach the bus.
    logic [7:0] data_in_unused;
    logic [1:0] status_unused;
    assign data_in_unused = bus.data_in;
    assign status_unused  = status[5:4];

    assign take = (state_reg == IDLE) && instr_boundary &&
                  (nmi_pending || (!irq_n && !i_flag));

`ifdef INTSEQ_NMI_EN
    logic nmi_prev_reg;
    logic nmi_edge;

    assign nmi_edge = nmi_prev_reg && !nmi_n;

    // A fresh edge in the take cycle wins over clearing the request being served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_prev_reg <= 1'b1;
            nmi_pending  <= 1'b0;
        end else begin
            nmi_prev_reg <= nmi_n;
            if (nmi_edge)
                nmi_pending <= 1'b1;
            else if (take && nmi_pending)
                nmi_pending <= 1'b0;
        end
    end
`else
    logic nmi_n_unused;
    assign nmi_n_unused = nmi_n;
    assign nmi_pending  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RESET;
            pc_hold_reg <= 16'h0000;
            kind_reg    <= KIND_IRQ;
        end else begin
            state_reg <= state_next;
            if (take) begin
                pc_hold_reg <= pc;
                kind_reg    <= nmi_pending ? KIND_NMI : KIND_IRQ;
            end
        end
    end

    assign vec_base = (kind_reg == KIND_NMI) ? NMI_VECTOR : IRQ_VECTOR;

    always_comb begin
        state_next     = state_reg;
        bus.busy       = 1'b1;
        bus.addr       = 16'h0000;
        bus.data_out   = 8'h00;
        bus.read_write = 1'b0;
        sp_decrement   = 1'b0;
        pcl_load       = 1'b0;
        pch_load       = 1'b0;
        set_i          = 1'b0;
        case (state_reg)
            RESET: begin
                bus.addr   = RESET_VECTOR;
                state_next = RST_L;
            end
            RST_L: begin
                bus.addr   = RESET_VECTOR;
                pcl_load   = 1'b1;
                state_next = RST_H;
            end
            RST_H: begin
                bus.addr   = RESET_VECTOR + 16'd1;
                pch_load   = 1'b1;
                state_next = IDLE;
            end
            IDLE: begin
                bus.busy = take;
                if (take)
                    state_next = PUSH_PCH;
            end
            PUSH_PCH: begin
                bus.addr       = {STACK_PAGE, sp};
                bus.data_out   = pc_hold_reg[15:8];
                bus.read_write = 1'b1;
                sp_decrement   = 1'b1;
                state_next     = PUSH_PCL;
            end
            PUSH_PCL: begin
                bus.addr       = {STACK_PAGE, sp};
                bus.data_out   = pc_hold_reg[7:0];
                bus.read_write = 1'b1;
                sp_decrement   = 1'b1;
                state_next     = PUSH_P;
            end
            PUSH_P: begin
                bus.addr       = {STACK_PAGE, sp};
                bus.data_out   = {status[7:6], 1'b1, 1'b0, status[3:0]};
                bus.read_write = 1'b1;
                sp_decrement   = 1'b1;
                state_next     = VEC_L;
            end
            VEC_L: begin
                bus.addr   = vec_base;
                pcl_load   = 1'b1;
                set_i      = 1'b1;
                state_next = VEC_H;
            end
            VEC_H: begin
                bus.addr   = vec_base + 16'd1;
                pch_load   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = RESET;
            end
        endcase
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer with a small memory and CPU register model.
module tb_interrupt_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, nmi_n, irq_n, instr_boundary;
    logic [7:0]  status;
    logic [15:0] pc_r;
    logic [7:0]  sp_r;
    logic        i_r;
    logic        host_we, host_i;
    logic [15:0] host_pc;
    logic [7:0]  host_sp;
    logic        sp_decrement, pcl_load, pch_load, set_i;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    interrupt_sequencer_if bus ();

    interrupt_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .nmi_n          (nmi_n),
        .irq_n          (irq_n),
        .i_flag         (i_r),
        .instr_boundary (instr_boundary),
        .pc             (pc_r),
        .status         (status),
        .sp             (sp_r),
        .bus            (bus),
        .sp_decrement   (sp_decrement),
        .pcl_load       (pcl_load),
        .pch_load       (pch_load),
        .set_i          (set_i)
    );

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        case (a)
            16'hFFFA: return 8'h00;
            16'hFFFB: return 8'hA0;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'h00;
            16'hFFFF: return 8'h90;
            default:  return 8'hEA;
        endcase
    endfunction

    always_comb bus.data_in = mem_rd(bus.addr);

    // External PC / SP / P.I registers driven by the strobes
    always @(posedge clk) begin
        if (host_we) begin
            pc_r <= host_pc;
            sp_r <= host_sp;
            i_r  <= host_i;
        end else begin
            if (sp_decrement) sp_r <= sp_r - 8'd1;
            if (pcl_load)     pc_r[7:0]  <= bus.data_in;
            if (pch_load)     pc_r[15:8] <= bus.data_in;
            if (set_i)        i_r <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare {busy, addr, data_out, read_write, sp_dec, pcl, pch, set_i}
    task automatic cyc(input string tag, input logic b, input logic [15:0] a,
                       input logic [7:0] d, input logic rw, input logic [3:0] st);
        chk(tag, {2'b00, bus.busy, bus.addr, bus.data_out, bus.read_write,
                  sp_decrement, pcl_load, pch_load, set_i},
                 {2'b00, b, a, d, rw, st});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic [15:0] p, input logic [7:0] s, input logic i);
        step();
        host_pc = p;
        host_sp = s;
        host_i  = i;
        host_we = 1'b1;
        step();
        host_we = 1'b0;
    endtask

    // Checks the five cycles after a take; expected values come from the caller.
    task automatic entry(input string tag, input logic [7:0] sp0, input logic [15:0] pc0,
                         input logic [15:0] vec, input logic nmi_at_pcl);
        step();
        instr_boundary = 1'b0;
        #1 cyc({tag, "_pch"}, 1'b1, {8'h01, sp0}, pc0[15:8], 1'b1, 4'b1000);
        step();
        if (nmi_at_pcl) nmi_n = 1'b0;
        irq_n = 1'b1;
        #1 cyc({tag, "_pcl"}, 1'b1, {8'h01, sp0 - 8'd1}, pc0[7:0], 1'b1, 4'b1000);
        step();
        #1 cyc({tag, "_p"}, 1'b1, {8'h01, sp0 - 8'd2}, 8'h20, 1'b1, 4'b1000);
        step();
        #1 cyc({tag, "_vecl"}, 1'b1, vec, 8'h00, 1'b0, 4'b0101);
        step();
        #1 cyc({tag, "_vech"}, 1'b1, vec + 16'd1, 8'h00, 1'b0, 4'b0010);
    endtask

    initial begin
        rst_n = 1'b0; nmi_n = 1'b1; irq_n = 1'b1; instr_boundary = 1'b0;
        status = 8'h30; host_we = 1'b0; host_pc = 16'h0; host_sp = 8'h0; host_i = 1'b1;

        // Reset vector fetch
        step(); step();
        #1 cyc("reset", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0000);
        rst_n = 1'b1;
        #1 cyc("reset_hold", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0000);
        step(); #1 cyc("rst_l", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0100);
        step(); #1 cyc("rst_h", 1'b1, 16'hFFFD, 8'h00, 1'b0, 4'b0010);
        step(); instr_boundary = 1'b1;
        #1 cyc("rst_idle", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
        chk("rst_pc", {16'h0, pc_r}, 32'h0000_1234);

        // IRQ entry
        instr_boundary = 1'b0;
        set_cpu(16'h8003, 8'hFF, 1'b0);
        irq_n = 1'b0; instr_boundary = 1'b1;
        #1 cyc("irq_take", 1'b1, 16'h0000, 8'h00, 1'b0, 4'b0000);
        entry("irq", 8'hFF, 16'h8003, 16'hFFFE, 1'b0);
        step(); irq_n = 1'b0; instr_boundary = 1'b1;
        #1 cyc("irq_done", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
        chk("irq_regs", {7'h0, i_r, sp_r, pc_r}, {7'h0, 1'b1, 8'hFC, 16'h9000});

        // Masked IRQ over 10 boundaries
        for (int k = 0; k < 10; k++) begin
            step();
            #1 cyc("masked", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
        end
        instr_boundary = 1'b0; irq_n = 1'b1;

`ifdef INTSEQ_NMI_EN
        // NMI wins over IRQ; nmi_n then stays low
        set_cpu(16'h4000, 8'hFF, 1'b0);
        irq_n = 1'b0; nmi_n = 1'b0;
        step(); instr_boundary = 1'b1;
        #1 cyc("nmi_take", 1'b1, 16'h0000, 8'h00, 1'b0, 4'b0000);
        entry("nmi", 8'hFF, 16'h4000, 16'hFFFA, 1'b0);
        step(); irq_n = 1'b0; instr_boundary = 1'b1;
        #1 chk("nmi_pc", {16'h0, pc_r}, 32'h0000_A000);
        for (int k = 0; k < 10; k++) begin
            #1 cyc("nmi_held", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
            step();
        end
        instr_boundary = 1'b0; irq_n = 1'b1; nmi_n = 1'b1;

        // NMI edge during an IRQ sequence
        set_cpu(16'h5678, 8'h80, 1'b0);
        irq_n = 1'b0; instr_boundary = 1'b1;
        #1 cyc("irq2_take", 1'b1, 16'h0000, 8'h00, 1'b0, 4'b0000);
        entry("irq2", 8'h80, 16'h5678, 16'hFFFE, 1'b1);
        step(); instr_boundary = 1'b1;
        #1 cyc("nmi2_take", 1'b1, 16'h0000, 8'h00, 1'b0, 4'b0000);
        entry("nmi2", 8'h7D, 16'h9000, 16'hFFFA, 1'b0);
        step();
        #1 cyc("nmi2_done", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
        chk("nmi2_pc", {16'h0, pc_r}, 32'h0000_A000);
        instr_boundary = 1'b0; nmi_n = 1'b1;
`else
        // NMI input ignored
        nmi_n = 1'b0;
        step(); instr_boundary = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 cyc("nmi_ignored", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
            step();
        end
        instr_boundary = 1'b0; nmi_n = 1'b1;
`endif

        // Reset during PUSH_PCL with an NMI pending
        set_cpu(16'h2222, 8'h40, 1'b0);
        irq_n = 1'b0; instr_boundary = 1'b1;
        #1 cyc("rm_take", 1'b1, 16'h0000, 8'h00, 1'b0, 4'b0000);
        step(); instr_boundary = 1'b0; nmi_n = 1'b0;
        #1 cyc("rm_pch", 1'b1, 16'h0140, 8'h22, 1'b1, 4'b1000);
        step();
        #1 cyc("rm_pcl", 1'b1, 16'h013F, 8'h22, 1'b1, 4'b1000);
        rst_n = 1'b0;
        #1 cyc("rm_abort", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0000);
        step(); nmi_n = 1'b1; irq_n = 1'b1;
        step(); rst_n = 1'b1;
        #1 cyc("rm_reset", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0000);
        step(); #1 cyc("rm_rst_l", 1'b1, 16'hFFFC, 8'h00, 1'b0, 4'b0100);
        step(); #1 cyc("rm_rst_h", 1'b1, 16'hFFFD, 8'h00, 1'b0, 4'b0010);
        step(); instr_boundary = 1'b1;
        #1 cyc("rm_idle", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);
        chk("rm_pc", {16'h0, pc_r}, 32'h0000_1234);
        step();
        #1 cyc("rm_no_nmi", 1'b0, 16'h0000, 8'h00, 1'b0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Bus-owning sequencer for 6502 reset, IRQ and NMI entry. It sits beside control_unit on the CPU memory bus. At instruction boundaries it takes the bus, pushes PCH, PCL and P to page 1, loads PC from the selected vector and sets the I flag. After reset it fetches the reset vector before the first opcode fetch.

## Interface
- NMI_VECTOR, 16'hFFFA, low-byte address of the NMI vector
- RESET_VECTOR, 16'hFFFC, low-byte address of the reset vector
- IRQ_VECTOR, 16'hFFFE, low-byte address of the IRQ vector
- STACK_PAGE, 8'h01, high address byte for pushes

Ports:
- clk  in  1  system clock; all state changes on posedge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- nmi_n  in  1  NMI request, falling-edge triggered
- irq_n  in  1  IRQ request, level, active-low
- i_flag  in  1  current P.I (1 = IRQ masked)
- instr_boundary  in  1  high in the control_unit FETCH cycle
- pc  in  16  current program counter
- status  in  8  current P register
- sp  in  8  current stack pointer
- data_in  in  8  memory read data
- busy  out  1  sequencer owns bus; control_unit suppresses instruction_load and increment_pc
- addr  out  16  bus address while busy
- data_out  out  8  write data
- read_write  out  1  0 = read, 1 = write
- sp_decrement  out  1  decrement SP at the next posedge
- pcl_load  out  1  PC[7:0] <= data_in at the next posedge
- pch_load  out  1  PC[15:8] <= data_in at the next posedge
- set_i  out  1  P.I <= 1 at the next posedge

## Operation
- States and transitions:
  - RESET → RST_L → RST_H → IDLE.
  - IDLE → PUSH_PCH → PUSH_PCL → PUSH_P → VEC_L → VEC_H → IDLE.
- Reset values (rst_n low):
  - state = RESET, busy = 1, addr = RESET_VECTOR, read_write = 0, data_out = 8'h00.
  - All load, decrement and set_i strobes = 0.
  - nmi_pending = 0, nmi_prev = 1, pc_hold = 16'h0000, kind = IRQ.
- RESET: after rst_n deasserts, advance to RST_L on the next posedge.
- RST_L: addr = RESET_VECTOR, read, pcl_load = 1.
- RST_H: addr = RESET_VECTOR + 1, read, pch_load = 1.
- NMI detection:
  - nmi_prev <= nmi_n every cycle.
  - nmi_prev = 1 and nmi_n = 0 sets nmi_pending.
  - A held-low nmi_n produces one request only.
- Take condition, in IDLE only: instr_boundary & (nmi_pending | (~irq_n & ~i_flag)).
  - busy is asserted combinationally in the take cycle.
  - In the take cycle: latch pc_hold <= pc. Latch kind = NMI if nmi_pending, else IRQ.
  - If kind = NMI, clear nmi_pending in the take cycle.
  - A new NMI edge in the same cycle wins over the clear; nmi_pending stays 1.
- PUSH_PCH: addr = {STACK_PAGE, sp}, write pc_hold[15:8], sp_decrement = 1.
- PUSH_PCL: same addressing, write pc_hold[7:0], sp_decrement = 1.
- PUSH_P: same addressing, write {status[7:6], 1'b1, 1'b0, status[3:0]}, sp_decrement = 1.
- VEC_L: addr = selected vector, read, pcl_load = 1, set_i = 1.
- VEC_H: addr = selected vector + 1, read, pch_load = 1.
- kind is fixed for the whole sequence.
  - irq_n rising mid-sequence does not abort.
  - An NMI edge during an IRQ sequence stays pending.
- In IDLE with no take: busy = 0, strobes = 0, read_write = 0, addr = 16'h0000.
- SP wraps 8'h00 → 8'hFF; the external SP register handles the wrap. The block only uses sp as presented.

## Timing
- Outputs are Moore decodes of state, except busy in the take cycle.
- Reset exit: RST_L is the 2nd cycle after rst_n rises. The first control_unit FETCH with busy = 0 is the 4th cycle.
- Interrupt entry: take cycle plus 5 sequencer cycles, so busy is high for 6 cycles.
- The first handler opcode fetch is in the cycle after VEC_H.
- data_in must be valid within the same cycle as pcl_load/pch_load (combinational memory read).
- NMI edge to take: at the earliest, the first instr_boundary at least one cycle after the edge.
- rst_n falling in any state forces RESET immediately (asynchronous). The partial push is abandoned and the pending NMI is discarded.

## Configuration
- INTSEQ_NMI_EN defined: NMI edge detector, nmi_pending and NMI vector selection are present.
- INTSEQ_NMI_EN undefined:
  - nmi_n is ignored and nmi_pending is constant 0.
  - kind is always IRQ; NMI_VECTOR is unused.
  - State machine and timing are otherwise unchanged.

## Test plan
- Reset vector: mem[FFFC] = 34, mem[FFFD] = 12; release rst_n. Expect RST_L addr FFFC with pcl_load, then RST_H addr FFFD with pch_load. busy = 0 next cycle and PC = 16'h1234.
- IRQ: pc = 8003, sp = FF, status = 8'h30, i_flag = 0, irq_n = 0 at a boundary. Expect:
  - Writes 80@01FF, 03@01FE, 20@01FD; sp_decrement on 3 cycles.
  - Reads FFFE/FFFF; set_i in VEC_L; busy high for exactly 6 cycles.
- Masked IRQ: i_flag = 1, irq_n = 0 across 10 boundaries. Expect busy = 0 and no writes.
- NMI priority: NMI edge and irq_n = 0 before the same boundary. Expect vector reads at FFFA/FFFB.
- NMI held low: repeat the priority stimulus with nmi_n held low afterwards. Expect a single NMI sequence, and no IRQ re-entry while i_flag = 1.
- NMI during IRQ: edge at PUSH_PCL of an IRQ sequence. Expect the IRQ to complete with FFFE vector, then an NMI sequence at the next boundary.
- Reset mid-sequence: rst_n low during PUSH_PCL. Expect the same cycle to show read_write = 0 and all strobes = 0. After release, the reset vector sequence runs and the pending NMI is dropped.
